// File: rtl/vga_scan_engine.sv
// VGA timing/address generator with grayscale-to-RGB expansion, gated until the halt word is seen.
// Outputs lag the counters by one pixel tick; free-running, no backpressure. TEST_PATTERN_EN adds colour bars.
module vga_scan_engine #(
   parameter int          CLK_DIV   = 2,
   parameter int          H_ACTIVE  = 640,
   parameter int          H_FP      = 16,
   parameter int          H_SYNC    = 96,
   parameter int          H_BP      = 48,
   parameter int          V_ACTIVE  = 480,
   parameter int          V_FP      = 10,
   parameter int          V_SYNC    = 2,
   parameter int          V_BP      = 33,
   parameter int          ADDR_W    = 19,
   parameter logic [31:0] HALT_WORD = 32'h9EFFFFFE
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [31:0]       instr,
   input  logic [7:0]        byte_in,
`ifdef TEST_PATTERN_EN
   input  logic              test_mode,
`endif
   output logic [ADDR_W-1:0] adr_byte,
   output logic              vga_clock,
   output logic              vga_hs,
   output logic              vga_vs,
   output logic              vga_blank,
   output logic [7:0]        r_out,
   output logic [7:0]        g_out,
   output logic [7:0]        b_out,
   output logic              frame_start,
   output logic              bandera
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int DW      = $clog2(CLK_DIV);
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);

   localparam logic [DW-1:0]     DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [DW-1:0]     DIV_HALF = DW'(CLK_DIV / 2);
   localparam logic [HW-1:0]     H_LAST   = HW'(H_TOTAL - 1);
   localparam logic [HW-1:0]     H_ACT    = HW'(H_ACTIVE);
   localparam logic [HW-1:0]     HS_BEG   = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0]     HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [VW-1:0]     V_LAST   = VW'(V_TOTAL - 1);
   localparam logic [VW-1:0]     V_ACT    = VW'(V_ACTIVE);
   localparam logic [VW-1:0]     VS_BEG   = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0]     VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [ADDR_W-1:0] PIX_LAST = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

   typedef enum logic [1:0] {WAIT, ARMED, SHOW} state_t;

   state_t            state, state_nxt;
   logic [DW-1:0]     div_cnt;
   logic [HW-1:0]     h_cnt;
   logic [VW-1:0]     v_cnt;
   logic [ADDR_W-1:0] addr;
   logic              tick, h_wrap, v_wrap, frame_wrap;
   logic              active, hs_raw, vs_raw, halt_seen;
   logic [7:0]        pix_r, pix_g, pix_b;

   assign tick       = (div_cnt == DIV_LAST);
   assign h_wrap     = (h_cnt == H_LAST);
   assign v_wrap     = (v_cnt == V_LAST);
   assign frame_wrap = tick && h_wrap && v_wrap;
   assign active     = (h_cnt < H_ACT) && (v_cnt < V_ACT);
   assign hs_raw     = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
   assign vs_raw     = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
   assign halt_seen  = (instr == HALT_WORD);
   assign adr_byte   = addr;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         div_cnt   <= '0;
         vga_clock <= 1'b0;
      end else begin
         div_cnt   <= tick ? '0 : div_cnt + 1'b1;
         vga_clock <= (div_cnt < DIV_HALF);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (tick) begin
         if (h_wrap) begin
            h_cnt <= '0;
            v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
         end else begin
            h_cnt <= h_cnt + 1'b1;
         end
      end
   end

   // Address tracks the pixel under the counters; it parks on the last pixel through blanking.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         addr <= '0;
      end else if (frame_wrap) begin
         addr <= '0;
      end else if (tick && active && (addr != PIX_LAST)) begin
         addr <= addr + 1'b1;
      end
   end

`ifdef TEST_PATTERN_EN
   localparam int             BAR_W    = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
   localparam int             BW       = (BAR_W > 1) ? $clog2(BAR_W) : 1;
   localparam logic [BW-1:0]  BAR_LAST = BW'(BAR_W - 1);

   logic [BW-1:0] bar_cnt;
   logic [2:0]    bar_idx;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bar_cnt <= '0;
         bar_idx <= '0;
      end else if (tick) begin
         if (h_wrap) begin
            bar_cnt <= '0;
            bar_idx <= '0;
         end else if (h_cnt < H_ACT) begin
            if (bar_cnt == BAR_LAST) begin
               bar_cnt <= '0;
               bar_idx <= bar_idx + 1'b1;
            end else begin
               bar_cnt <= bar_cnt + 1'b1;
            end
         end
      end
   end
`endif

   // Bar order white..black maps each channel onto one inverted bit of the bar index.
   always_comb begin
      pix_r = byte_in;
      pix_g = byte_in;
      pix_b = byte_in;
`ifdef TEST_PATTERN_EN
      if (test_mode) begin
         pix_r = {8{~bar_idx[1]}};
         pix_g = {8{~bar_idx[2]}};
         pix_b = {8{~bar_idx[0]}};
      end
`endif
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vga_hs    <= 1'b1;
         vga_vs    <= 1'b1;
         vga_blank <= 1'b0;
         r_out     <= '0;
         g_out     <= '0;
         b_out     <= '0;
      end else if (tick) begin
         vga_hs    <= hs_raw;
         vga_vs    <= vs_raw;
         vga_blank <= active;
         if ((state == SHOW) && active) begin
            r_out <= pix_r;
            g_out <= pix_g;
            b_out <= pix_b;
         end else begin
            r_out <= '0;
            g_out <= '0;
            b_out <= '0;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         frame_start <= 1'b0;
         bandera     <= 1'b0;
         state       <= WAIT;
      end else begin
         frame_start <= frame_wrap;
         if (halt_seen) bandera <= 1'b1;
         state <= state_nxt;
      end
   end

   // A halt on the boundary tick only arms, so display never starts mid-frame.
   always_comb begin
      state_nxt = state;
      case (state)
         WAIT:    if (halt_seen)  state_nxt = ARMED;
         ARMED:   if (frame_wrap) state_nxt = SHOW;
         SHOW:    state_nxt = SHOW;
         default: state_nxt = WAIT;
      endcase
   end

endmodule

// File: tb/tb_vga_scan_engine.sv
// Bench for vga_scan_engine on a reduced 8x4 raster (15 ticks/line, 8 lines/frame, 2 clks/tick).
module tb_vga_scan_engine;

   localparam logic [31:0] HALT    = 32'h9EFFFFFE;
   localparam int          NO_HALT = 100000;

   typedef struct packed {
      logic       hs, vs, blank, vclk, fs, band;
      logic [7:0] r, g, b, adr;
   } obs_t;

   typedef struct {
      int   e;
      obs_t exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] instr;
   logic [7:0]  byte_in;
   logic [7:0]  adr_byte;
   logic        vga_clock, vga_hs, vga_vs, vga_blank, frame_start, bandera;
   logic [7:0]  r_out, g_out, b_out;
`ifdef TEST_PATTERN_EN
   logic        test_mode = 1'b0;
`endif

   int   tests = 0;
   int   fails = 0;
   obs_t sb[$];

   always #5 clk = ~clk;
   assign byte_in = adr_byte;

   vga_scan_engine #(
      .CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .ADDR_W(8), .HALT_WORD(HALT)
   ) dut (
      .clk(clk), .reset(reset), .instr(instr), .byte_in(byte_in),
`ifdef TEST_PATTERN_EN
      .test_mode(test_mode),
`endif
      .adr_byte(adr_byte), .vga_clock(vga_clock), .vga_hs(vga_hs), .vga_vs(vga_vs),
      .vga_blank(vga_blank), .r_out(r_out), .g_out(g_out), .b_out(b_out),
      .frame_start(frame_start), .bandera(bandera)
   );

   function automatic obs_t mk(input logic hs, vs, blank, vclk, fs, input int adr);
      obs_t x;
      x       = '0;
      x.hs    = hs;
      x.vs    = vs;
      x.blank = blank;
      x.vclk  = vclk;
      x.fs    = fs;
      x.adr   = 8'(adr);
      return x;
   endfunction

   function automatic obs_t sample();
      obs_t s;
      s.hs = vga_hs; s.vs = vga_vs; s.blank = vga_blank; s.vclk = vga_clock;
      s.fs = frame_start; s.band = bandera;
      s.r = r_out; s.g = g_out; s.b = b_out; s.adr = adr_byte;
      return s;
   endfunction

   function automatic string fmt(input obs_t x);
      return $sformatf("hs=%b vs=%b blank=%b vclk=%b fs=%b band=%b rgb=%h/%h/%h adr=%0d",
                       x.hs, x.vs, x.blank, x.vclk, x.fs, x.band, x.r, x.g, x.b, x.adr);
   endfunction

   task automatic check(input string nm, input obs_t act, input obs_t exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %s, expected %s", nm, fmt(act), fmt(exp));
      end
   endtask

   // Pixels already swept within the frame up to raster position pos, clamped to the last address.
   function automatic int addr_of(input int pos);
      int h, v, c;
      h = pos % 15;
      v = pos / 15;
      if (v >= 4) c = 32;
      else        c = v * 8 + ((h < 8) ? h : 8);
      return (c > 31) ? 31 : c;
   endfunction

   // Expected outputs after edge e (counted from reset release) given the edge the halt word was applied.
   function automatic obs_t model(input int e, input int halt_e);
      obs_t x;
      int   k, q, h, v, show_e;
      logic act;
      x      = '0;
      k      = e / 2;
      x.vclk = (e % 2 == 1);
      x.adr  = 8'(addr_of(k % 120));
      x.fs   = (e > 0) && (e % 240 == 0);
      x.band = (e >= halt_e);
      x.hs   = 1'b1;
      x.vs   = 1'b1;
      if (k > 0) begin
         q       = (k - 1) % 120;
         h       = q % 15;
         v       = q / 15;
         act     = (h < 8) && (v < 4);
         x.hs    = !(h >= 10 && h < 13);
         x.vs    = !(v >= 5 && v < 7);
         x.blank = act;
         show_e  = (halt_e / 240 + 1) * 240;
         if (act && (2 * k > show_e)) begin
            x.r = 8'(addr_of(q));
            x.g = x.r;
            x.b = x.r;
         end
      end
      return x;
   endfunction

   function automatic logic [31:0] other_instr();
      return $urandom | 32'h1;
   endfunction

   task automatic run_seg(input int n, input int halt_e, input string tag);
      obs_t a, x;
      for (int e = 1; e <= n; e++) begin
         instr = (e == halt_e) ? HALT : other_instr();
         @(posedge clk);
         sb.push_back(model(e, halt_e));
         @(negedge clk);
         a = sample();
         x = sb.pop_front();
         check($sformatf("%s e=%0d", tag, e), a, x);
      end
      instr = other_instr();
   endtask

   initial begin
      vec_t tbl[19];
      obs_t rst_obs;
      int   e;

      rst_obs = mk(1, 1, 0, 0, 0, 0);
      //              e      hs vs bl vclk fs adr
      tbl[0]  = '{1,   mk(1, 1, 0, 1, 0, 0)};
      tbl[1]  = '{2,   mk(1, 1, 1, 0, 0, 1)};
      tbl[2]  = '{16,  mk(1, 1, 1, 0, 0, 8)};
      tbl[3]  = '{18,  mk(1, 1, 0, 0, 0, 8)};
      tbl[4]  = '{22,  mk(0, 1, 0, 0, 0, 8)};
      tbl[5]  = '{26,  mk(0, 1, 0, 0, 0, 8)};
      tbl[6]  = '{28,  mk(1, 1, 0, 0, 0, 8)};
      tbl[7]  = '{31,  mk(1, 1, 0, 1, 0, 8)};
      tbl[8]  = '{32,  mk(1, 1, 1, 0, 0, 9)};
      tbl[9]  = '{104, mk(1, 1, 1, 0, 0, 31)};
      tbl[10] = '{106, mk(1, 1, 1, 0, 0, 31)};
      tbl[11] = '{150, mk(1, 1, 0, 0, 0, 31)};
      tbl[12] = '{152, mk(1, 0, 0, 0, 0, 31)};
      tbl[13] = '{211, mk(1, 0, 0, 1, 0, 31)};
      tbl[14] = '{212, mk(1, 1, 0, 0, 0, 31)};
      tbl[15] = '{239, mk(1, 1, 0, 1, 0, 31)};
      tbl[16] = '{240, mk(1, 1, 0, 0, 1, 0)};
      tbl[17] = '{241, mk(1, 1, 0, 1, 0, 0)};
      tbl[18] = '{242, mk(1, 1, 1, 0, 0, 1)};

      reset = 1'b0;
      instr = 32'h0;
      repeat (3) @(negedge clk);
      check("reset state", sample(), rst_obs);

      // Landmarks of the line/frame timing with the display still gated.
      reset = 1'b1;
      e = 0;
      for (int i = 0; i < 19; i++) begin
         while (e < tbl[i].e) begin
            instr = other_instr();
            @(posedge clk);
            e++;
            @(negedge clk);
         end
         check($sformatf("timing e=%0d", tbl[i].e), sample(), tbl[i].exp);
      end

      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      // Halt mid-frame 2: gated until edge 480, frame 3 shows 0..31; stop mid-line in SHOW.
      run_seg(527, 300, "gate");

      #2 reset = 1'b0;
      #1 check("async reset in SHOW", sample(), rst_obs);
      repeat (2) @(negedge clk);
      reset = 1'b1;

      // Halt lands on the boundary tick itself: frame 2 stays dark, frame 3 shows.
      run_seg(720, 240, "rearm");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/vga_scan_engine.md
Name: vga_scan_engine

Overview:
- Parametrised successor to the fixed 640x480 VGA path in the image-filter top level.
- Generates the pixel-clock enable, VGA timing and framebuffer read addresses internally, and expands 8-bit grayscale bytes onto RGB.
- Gates display until the filter processor reaches its halt word, then starts on a clean frame boundary.
- Sits between the processor's image memory port and the DAC/VGA pins.

Parameters:
- CLK_DIV, 2: system clocks per pixel; must be ≥2.
- H_ACTIVE, 640: visible pixels per line.
- H_FP, 16: horizontal front porch, in pixels.
- H_SYNC, 96: horizontal sync width, in pixels.
- H_BP, 48: horizontal back porch, in pixels.
- V_ACTIVE, 480: visible lines.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC, 2: vertical sync width, in lines.
- V_BP, 33: vertical back porch, in lines.
- ADDR_W, 19: framebuffer address width; must hold H_ACTIVE*V_ACTIVE-1.
- HALT_WORD, 32'h9EFFFFFE: processor instruction that marks filter completion.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- instr  in  32  processor instruction currently executing.
- byte_in  in  8  framebuffer read data for adr_byte.
- adr_byte  out  ADDR_W  framebuffer read address.
- vga_clock  out  1  pixel clock to DAC; duty ≈50%.
- vga_hs  out  1  horizontal sync, active-low.
- vga_vs  out  1  vertical sync, active-low.
- vga_blank  out  1  0 during blanking, 1 during visible pixels.
- r_out  out  8  red.
- g_out  out  8  green.
- b_out  out  8  blue.
- frame_start  out  1  one-clk pulse at the first pixel tick of each frame.
- bandera  out  1  sticky: halt word has been seen.
- test_mode  in  1  only present with TEST_PATTERN_EN.

Behaviour:
- Reset (reset=0, asynchronous):
  - all counters are 0; adr_byte=0.
  - vga_hs=1, vga_vs=1, vga_blank=0, vga_clock=0.
  - r/g/b=0, frame_start=0, bandera=0, state=WAIT.
- Divider:
  - div_cnt runs 0..CLK_DIV-1 and wraps; tick is asserted when div_cnt==CLK_DIV-1.
  - vga_clock is a registered (div_cnt < CLK_DIV/2).
- h_cnt:
  - Range 0..H_TOTAL-1, with H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP.
  - Advances only on tick; wraps to 0 and advances v_cnt.
- v_cnt:
  - Range 0..V_TOTAL-1, wraps to 0.
  - Wrap of both counters defines the frame boundary.
- Region decode:
  - Active region: h_cnt<H_ACTIVE and v_cnt<V_ACTIVE.
  - hs_raw is low for H_ACTIVE+H_FP ≤ h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - vs_raw is defined the same way with the V parameters.
- Address:
  - adr_byte = addr counter, driven combinationally.
  - Counter clears to 0 on the tick where h_cnt=0 and v_cnt=0.
  - Increments on every tick inside the active region.
  - Never exceeds H_ACTIVE*V_ACTIVE-1.
  - No multiplier is used.
- Pipeline:
  - On each tick, the outputs register the previous tick's hs_raw, vs_raw, active flag and byte_in.
  - Outputs therefore lag the counters by exactly one pixel tick.
  - byte_in must be valid within CLK_DIV-1 clks of an address change.
- State machine:
  - WAIT: sync outputs run normally; vga_blank follows the region decode; RGB is forced to 0.
  - WAIT→ARMED: on any clk where instr==HALT_WORD; bandera sets and stays 1 until reset.
  - ARMED: behaves as WAIT.
  - ARMED→SHOW: at the frame boundary tick.
  - SHOW: visible pixels output r=g=b=byte_in (delayed); blanked pixels output 0.
  - SHOW is terminal until reset.
- Halt word seen in SHOW: no effect.
- Halt word seen on the frame-boundary tick itself: goes to ARMED; SHOW begins at the next boundary, so no partial frame is ever shown.
- frame_start: pulses on the clk of the boundary tick in all states.
- Reset mid-frame: all outputs return immediately to their reset values; timing restarts at h=v=0 after release.

Optional Feature:
- Macro: TEST_PATTERN_EN.
- Defined:
  - test_mode port exists.
  - In SHOW with test_mode=1, RGB shows 8 vertical colour bars, each H_ACTIVE/8 wide, ordered white, yellow, cyan, green, magenta, red, blue, black.
  - Channel values are 8'hFF or 8'h00.
  - adr_byte still advances.
  - With test_mode=0, SHOW outputs the grayscale path.
- Undefined: no test_mode port; grayscale path only.

Test Plan:
- Timing, with H_ACTIVE=8, H_FP=2, H_SYNC=3, H_BP=2, V_ACTIVE=4, V_FP=1, V_SYNC=2, V_BP=1, CLK_DIV=2:
  - vga_hs is low for 3 ticks starting at tick 10 of each line, plus the 1-tick output lag.
  - Line period is 15 ticks = 30 clks; frame period is 8 lines.
  - frame_start pulses every 240 clks.
- Address sweep, same parameters:
  - adr_byte runs 0..31 across the active region; holds during blanking.
  - Returns to 0 at the frame boundary.
- Gating:
  - byte_in = adr_byte[7:0] with no halt word → RGB stays 0 and bandera=0.
  - Pulse instr=32'h9EFFFFFE mid-frame → bandera=1 next clk.
  - RGB stays 0 for the rest of that frame.
  - Next frame, r_out=g_out=b_out = 0,1,2,… one tick after each address.
- Reset asynchronously mid-line in SHOW:
  - All outputs reach their reset values without waiting for a clk edge.
  - bandera clears.
  - After release, hs first falls at tick 10 and RGB stays 0 until the halt word is seen again.
- TEST_PATTERN_EN with test_mode=1 in SHOW:
  - Pixels 0..7 of a line output white, yellow, cyan, green, magenta, red, blue, black (1 pixel per bar).
  - Example values: yellow = FF/FF/00, blue = 00/00/FF.
